// File: rtl/led_blink_if.sv
// Request/status bundle between event logic and the LED blink driver.
// Signal prefixes are from the driver's point of view.
interface led_blink_if #(
  parameter int PEND_W = 4
);
  logic              i_trig;
  logic              i_clr_ovf;
  logic              o_led;
  logic              o_busy;
  logic [PEND_W-1:0] o_pending;
  logic              o_ovf;

  modport master (
    output i_trig, i_clr_ovf,
    input  o_led, o_busy, o_pending, o_ovf
  );

  modport slave (
    input  i_trig, i_clr_ovf,
    output o_led, o_busy, o_pending, o_ovf
  );
endinterface

// File: rtl/led_blink_driver.sv
// Turns single-cycle event requests into fixed-length LED blinks separated by a fixed gap.
// Requests that arrive while a blink is running are queued in a saturating counter.
//
//   state  | meaning
//   IDLE   | LED unlit, nothing running
//   ON     | LED lit, counting ON_CYCLES
//   GAP    | LED unlit, counting OFF_CYCLES
module led_blink_driver #(
  parameter int unsigned ON_CYCLES      = 20'd10000,
  parameter int unsigned OFF_CYCLES     = 20'd10000,
  parameter int          CNT_W          = 20,
  parameter int          PEND_W         = 4,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input logic         clk,
  input logic         rstn,
  led_blink_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic              LED_LIT   = ~LED_ACTIVE_LOW;
  localparam logic              LED_UNLIT = LED_ACTIVE_LOW;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [PEND_W-1:0] r_pending;
  logic              r_ovf;
  logic              r_busy;
  logic              r_led;

  logic              w_gap_last;
  logic              w_start;
  logic              w_take;
  logic              w_dec;
  logic              w_inc;
  logic              w_drop;
  logic              w_active_next;
  logic [PEND_W-1:0] w_pend_next;

  always_comb begin
    w_gap_last    = (r_state == S_GAP) && (r_cnt == OFF_LAST);
    w_start       = bus.i_trig || (r_pending != '0);
    w_take        = w_start && ((r_state == S_IDLE) || w_gap_last);
    w_dec         = w_take && (r_pending != '0);
    // a trig that starts a blink straight away is not queued
    w_inc         = bus.i_trig && !(w_take && (r_pending == '0));
    w_drop        = w_inc && !w_dec && (r_pending == PEND_MAX);
    w_active_next = w_take || (r_state == S_ON) || ((r_state == S_GAP) && !w_gap_last);
    w_pend_next   = r_pending;
    if (w_inc && !w_dec && !w_drop) begin
      w_pend_next = r_pending + 1'b1;
    end else if (w_dec && !w_inc) begin
      w_pend_next = r_pending - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_led     <= LED_UNLIT;
    end else begin
      r_pending <= w_pend_next;
      r_ovf     <= w_drop || (r_ovf && !bus.i_clr_ovf);
      r_busy    <= w_active_next || (w_pend_next != '0);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_take) begin
            r_state <= S_ON;
            r_led   <= LED_LIT;
          end
        end
        S_ON: begin
          if (r_cnt == ON_LAST) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
            r_led   <= LED_UNLIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_gap_last) begin
            r_cnt <= '0;
            if (w_take) begin
              r_state <= S_ON;
              r_led   <= LED_LIT;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_led   <= LED_UNLIT;
        end
      endcase
    end
  end

  assign bus.o_led     = r_led;
  assign bus.o_busy    = r_busy;
  assign bus.o_pending = r_pending;
  assign bus.o_ovf     = r_ovf;

endmodule

// File: doc/led_blink_driver.md
# led_blink_driver

Output-side counterpart to the team's button input debouncer. It turns single-cycle event requests from core logic into human-visible LED blinks. Each request becomes exactly one blink of fixed on-time, followed by a fixed off-gap. Requests that arrive while a blink is in progress are counted and replayed in order, so no request is lost up to the queue depth. The block sits between status/event logic (for example CAN frame received or error flags) and a board LED pin.

## Interface
- ON_CYCLES, 20'd10000: LED-active duration per blink, in clk cycles; must be ≥1.
- OFF_CYCLES, 20'd10000: mandatory LED-inactive gap after each blink, in clk cycles; must be ≥1.
- CNT_W, 20: width of the duration counter; must hold max(ON_CYCLES, OFF_CYCLES)-1.
- PEND_W, 4: width of the pending-request counter.
- LED_ACTIVE_LOW, 0: 1 means the led output is driven low when lit.
- clk input 1: system clock.
- rstn input 1: reset, asynchronous, active-low. Clock is clk.
- trig input 1: blink request, sampled on every rising edge of clk. Each high cycle counts as one request.
- clr_ovf input 1: synchronous clear of ovf.
- led output 1: registered LED drive, polarity set by LED_ACTIVE_LOW.
- busy output 1: registered; high while state≠IDLE or pending≠0.
- pending output PEND_W: registered count of queued blinks not yet started.
- ovf output 1: registered, sticky; set when a request is dropped.

## Operation
- FSM states: IDLE, ON, GAP. A CNT_W counter cnt is cleared on entry to every state.
- The start condition is start = trig | (pending≠0). It is evaluated only in IDLE and on the last GAP cycle.
- IDLE:
  - If start, go to ON; otherwise stay in IDLE.
- ON:
  - led is lit.
  - When cnt == ON_CYCLES-1, go to GAP; otherwise cnt increments.
- GAP:
  - led is unlit.
  - When cnt == OFF_CYCLES-1: if start, go to ON; otherwise go to IDLE.
  - Otherwise cnt increments.
- Pending update applies every cycle, as pending_next = pending + inc − dec:
  - dec = 1 when a start is taken (IDLE or last GAP cycle) and pending≠0.
  - inc = 1 when trig is high and the trig is not itself consumed by a start with pending==0.
  - trig and dec in the same cycle leave pending unchanged: one queued request starts, and the new one is queued.
- Saturation:
  - If inc=1 and pending == 2^PEND_W−1, pending holds and ovf is set to 1. The request is dropped.
- ovf:
  - clr_ovf clears it.
  - If clr_ovf and an overflow occur in the same cycle, set wins and ovf = 1.
- Reset (asynchronous, including mid-blink): state=IDLE, cnt=0, pending=0, ovf=0, busy=0, led=LED_ACTIVE_LOW (unlit). All queued requests are discarded.
- Arithmetic: all counters are unsigned and never wrap. cnt stops at its terminal value, and pending saturates.

## Timing
- Latency: trig high at edge k while in IDLE makes led lit from edge k+1. It stays lit for exactly ON_CYCLES cycles, then unlit for exactly OFF_CYCLES cycles.
- Back-to-back blinks have a period of exactly ON_CYCLES+OFF_CYCLES. No extra IDLE cycle occurs between queued blinks, including when trig is high on the last GAP cycle.
- busy:
  - Rises at edge k+1 after the triggering edge.
  - Falls on the same edge that led's final GAP ends and the FSM enters IDLE with pending==0.
- pending and ovf update on the same edge that samples the causing trig.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2 unless stated otherwise.
- Single trig pulse at edge 0 → led lit during cycles 1–4, unlit 5–7. busy is high for cycles 1–7 and 0 at cycle 8. pending stays 0.
- trig held high for 3 cycles starting at edge 0 → 3 blinks, with led rising at cycles 1, 8 and 15. pending goes 0→1→2, then 1 at edge 7 and 0 at edge 14. ovf stays 0.
- 5 single-cycle trigs during the first ON phase → pending saturates at 3 and ovf=1 after the 5th. Exactly 4 blinks occur. A clr_ovf pulse afterwards returns ovf to 0.
- trig on the last GAP cycle of a lone blink → the next ON begins on the very next edge (gap exactly 3 cycles), with pending remaining 0.
- rstn asserted for 1 cycle mid-ON while pending=2 → led goes unlit immediately, asynchronously. pending=0, busy=0, ovf=0, and no further blinks occur.
- LED_ACTIVE_LOW=1 with a single trig → led=1 out of reset, and 0 during exactly cycles 1–4.
